// File: rtl/dmem_ctrl_pkg.sv
// Shared CPU data-memory types: address/data widths, access size, alignment helper.
package cpuDefine;

  localparam int addrLen = 32;
  localparam int dataLen = 32;

  typedef logic [addrLen-1:0] Addr;
  typedef logic [dataLen-1:0] DType;

  typedef enum logic [1:0] {
    MEM_B = 2'd0,
    MEM_H = 2'd1,
    MEM_W = 2'd2
  } MemSize;

  // A halfword must sit on an even address, a word on a multiple of four.
  function automatic logic is_misaligned(input MemSize size, input logic [1:0] lo);
    return ((size == MEM_H) && lo[0]) || ((size == MEM_W) && (lo != 2'b00));
  endfunction

endpackage

// File: rtl/dmem_align.sv
// Byte-lane steering for the data RAM: load extract with sign/zero extension,
// and read-modify-write merge of sub-word store data into an old word.
module dmem_align
  import cpuDefine::*;
(
  input  MemSize     size_i,
  input  logic       signed_i,
  input  logic [1:0] addr_lo_i,
  input  DType       rdata_i,
  input  DType       old_i,
  input  DType       wdata_i,
  output DType       load_o,
  output DType       merge_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Lane select, extension and merge are purely combinational.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a value held (no latch).
    byte_v  = rdata_i[{addr_lo_i, 3'b000} +: 8];
    half_v  = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    load_o  = rdata_i;
    merge_o = old_i;
    case (size_i)
      MEM_B: begin
        load_o = {{24{signed_i & byte_v[7]}}, byte_v};
        merge_o[{addr_lo_i, 3'b000} +: 8] = wdata_i[7:0];
      end
      MEM_H: begin
        load_o = {{16{signed_i & half_v[15]}}, half_v};
        if (addr_lo_i[1]) merge_o[31:16] = wdata_i[15:0];
        else              merge_o[15:0]  = wdata_i[15:0];
      end
      default: begin
        load_o  = rdata_i;
        merge_o = wdata_i;
      end
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Two-port data-memory controller: arbitrates LSU (port 0) and debug/DMA
// (port 1), performs aligned loads/stores with read-modify-write for
// sub-word stores, and flags misaligned accesses.
module dmem_ctrl
  import cpuDefine::*;
#(
  parameter bit RR_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [1:0] req_valid,
  output logic [1:0] req_ready,
  input  logic [1:0] req_we,
  input  MemSize     req_size   [2],
  input  logic [1:0] req_signed,
  input  Addr        req_addr   [2],
  input  DType       req_wdata  [2],
  output logic [1:0] rsp_valid,
  output logic       rsp_err,
  output DType       rsp_rdata,
  output logic       memWriteEn,
  output Addr        readAddr,
  output Addr        writeAddr,
  output DType       writeData,
  input  DType       readData
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_MERGE  = 2'd2
  } state_e;

  state_e     state_q;
  logic       port_q;
  logic       we_q;
  MemSize     size_q;
  logic       signed_q;
  Addr        addr_q;
  DType       wdata_q;
  DType       old_q;
  logic       last_q;
  logic [1:0] rsp_valid_q;
  logic       rsp_err_q;
  DType       rsp_rdata_q;

  logic       win_port;
  logic       misalign;
  DType       load_data;
  DType       merge_data;
  Addr        word_addr;

  assign misalign  = is_misaligned(size_q, addr_q[1:0]);
  assign word_addr = {addr_q[addrLen-1:2], 2'b00};

  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

  dmem_align u_align (
    .size_i    (size_q),
    .signed_i  (signed_q),
    .addr_lo_i (addr_q[1:0]),
    .rdata_i   (readData),
    .old_i     (old_q),
    .wdata_i   (wdata_q),
    .load_o    (load_data),
    .merge_o   (merge_data)
  );

  // Arbitration: a lone requester wins; a tie goes to the port not granted
  // last (round-robin) or always to port 0 (fixed priority).
  always_comb begin
    win_port = 1'b0;
    case (req_valid)
      2'b10:   win_port = 1'b1;
      2'b11:   win_port = RR_EN ? ~last_q : 1'b0;
      default: win_port = 1'b0;
    endcase
    // NOTE: rstn gates ready directly so no port is accepted while reset is held.
    req_ready = ((state_q == S_IDLE) && rstn && (req_valid != 2'b00))
                ? {win_port, ~win_port} : 2'b00;
  end

  // RAM drive: addresses only while busy, write strobe only in the single
  // write cycle of a successful store.
  always_comb begin
    memWriteEn = 1'b0;
    readAddr   = '0;
    writeAddr  = '0;
    writeData  = '0;
    if (state_q != S_IDLE) begin
      readAddr  = word_addr;
      writeAddr = word_addr;
    end
    if ((state_q == S_ACCESS) && we_q && !misalign && (size_q == MEM_W)) begin
      memWriteEn = 1'b1;
      writeData  = wdata_q;
    end
    if (state_q == S_MERGE) begin
      memWriteEn = 1'b1;
      writeData  = merge_data;
    end
  end

  // Request FSM with registered response outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      port_q      <= 1'b0;
      we_q        <= 1'b0;
      size_q      <= MEM_W;
      signed_q    <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      old_q       <= '0;
      last_q      <= 1'b1;
      rsp_valid_q <= 2'b00;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout so every register samples pre-edge values.
      rsp_valid_q <= 2'b00;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      case (state_q)
        S_IDLE: begin
          if ((req_valid & req_ready) != 2'b00) begin
            port_q   <= win_port;
            we_q     <= req_we[win_port];
            size_q   <= req_size[win_port];
            signed_q <= req_signed[win_port];
            addr_q   <= req_addr[win_port];
            wdata_q  <= req_wdata[win_port];
            last_q   <= win_port;
            state_q  <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (misalign) begin
            rsp_valid_q <= {port_q, ~port_q};
            rsp_err_q   <= 1'b1;
            state_q     <= S_IDLE;
          end else if (!we_q) begin
            rsp_valid_q <= {port_q, ~port_q};
            rsp_rdata_q <= load_data;
            state_q     <= S_IDLE;
          end else if (size_q == MEM_W) begin
            rsp_valid_q <= {port_q, ~port_q};
            state_q     <= S_IDLE;
          end else begin
            old_q   <= readData;
            state_q <= S_MERGE;
          end
        end
        S_MERGE: begin
          rsp_valid_q <= {port_q, ~port_q};
          state_q     <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: byte-array reference model, response
// scoreboard with a decoupled monitor, directed and random stimulus.
module tb_dmem_ctrl;
  import cpuDefine::*;

  localparam bit RR = 1'b1;

  typedef struct {
    bit     we;
    MemSize size;
    bit     sgn;
    Addr    addr;
    DType   wdata;
  } txn_t;

  typedef struct {
    int   port;
    bit   err;
    DType rdata;
    int   cyc;
  } exp_t;

  logic       clk, rstn;
  logic [1:0] req_valid, req_ready, req_we, req_signed;
  MemSize     req_size  [2];
  Addr        req_addr  [2];
  DType       req_wdata [2];
  logic [1:0] rsp_valid;
  logic       rsp_err;
  DType       rsp_rdata;
  logic       memWriteEn;
  Addr        readAddr, writeAddr;
  DType       writeData, readData;

  logic [1:0] fp_valid, fp_ready, fp_rsp_valid;
  logic       fp_rsp_err, fp_mwe;
  DType       fp_rsp_rdata, fp_wdata, fp_rdata;
  Addr        fp_raddr, fp_waddr;

  logic [31:0] ram [256];
  logic        ram_clr;
  logic [7:0]  ref_mem [1024];
  exp_t        sb[$];

  int cyc = 0;
  int n_cmp = 0;
  int n_fail = 0;
  int next_ok = 0;
  bit mdl_last = 1'b1;
  int wr_exp = 0;
  int wr_seen = 0;

  dmem_ctrl #(.RR_EN(RR)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_err(rsp_err),
    .rsp_rdata(rsp_rdata), .memWriteEn(memWriteEn), .readAddr(readAddr),
    .writeAddr(writeAddr), .writeData(writeData), .readData(readData)
  );

  dmem_ctrl #(.RR_EN(1'b0)) dut_fp (
    .clk(clk), .rstn(rstn),
    .req_valid(fp_valid), .req_ready(fp_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(fp_rsp_valid), .rsp_err(fp_rsp_err),
    .rsp_rdata(fp_rsp_rdata), .memWriteEn(fp_mwe), .readAddr(fp_raddr),
    .writeAddr(fp_waddr), .writeData(fp_wdata), .readData(fp_rdata)
  );

  assign fp_rdata = '0;
  assign readData = ram[readAddr[9:2]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (ram_clr) begin
      for (int i = 0; i < 256; i++) ram[i] <= '0;
    end else if (memWriteEn) begin
      ram[writeAddr[9:2]] <= writeData;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h want 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic DType ref_load(input Addr a, input MemSize s, input bit sgn);
    int   n;
    DType v;
    n = (s == MEM_B) ? 1 : (s == MEM_H) ? 2 : 4;
    v = '0;
    for (int i = 0; i < n; i++) v = v | (DType'(ref_mem[(a + i) & 1023]) << (8 * i));
    if (sgn && n < 4 && v[8*n-1]) v = v | ~((DType'(1) << (8 * n)) - 1);
    return v;
  endfunction

  function automatic int model_winner(input logic [1:0] v);
    if (v == 2'b10) return 1;
    if (v == 2'b11 && RR) return mdl_last ? 0 : 1;
    return 0;
  endfunction

  // Apply one accepted request to the reference model and queue its response.
  task automatic model_transfer(input int port, input txn_t t);
    exp_t e;
    bit   mis;
    int   n;
    mis = (t.size == MEM_H && t.addr[0]) || (t.size == MEM_W && t.addr[1:0] != 2'b00);
    n = (t.size == MEM_B) ? 1 : (t.size == MEM_H) ? 2 : 4;
    e.port  = port;
    e.err   = mis;
    e.rdata = (!mis && !t.we) ? ref_load(t.addr, t.size, t.sgn) : '0;
    e.cyc   = cyc + ((t.we && !mis && n < 4) ? 3 : 2);
    if (t.we && !mis) begin
      for (int i = 0; i < n; i++) ref_mem[(t.addr + i) & 1023] = t.wdata[8*i +: 8];
      wr_exp++;
    end
    next_ok  = e.cyc;
    mdl_last = port[0];
    sb.push_back(e);
  endtask

  task automatic drive(input int p, input txn_t t);
    req_we[p]     = t.we;
    req_size[p]   = t.size;
    req_signed[p] = t.sgn;
    req_addr[p]   = t.addr;
    req_wdata[p]  = t.wdata;
  endtask

  function automatic txn_t mk(input bit we, input MemSize s, input bit sgn,
                              input Addr a, input DType d);
    txn_t t;
    t.we = we; t.size = s; t.sgn = sgn; t.addr = a; t.wdata = d;
    return t;
  endfunction

  function automatic txn_t rand_txn();
    txn_t t;
    t.we    = 1'($urandom_range(0, 1));
    t.size  = MemSize'($urandom_range(0, 2));
    t.sgn   = 1'($urandom_range(0, 1));
    t.addr  = Addr'($urandom_range(0, 255));
    t.wdata = $urandom;
    if ($urandom_range(0, 3) != 0) begin
      if (t.size == MEM_H) t.addr[0] = 1'b0;
      if (t.size == MEM_W) t.addr[1:0] = 2'b00;
    end
    return t;
  endfunction

  // Called at a falling edge: present requests, check ready each cycle until
  // a transfer happens, update the model, then drop valid after the edge.
  task automatic offer(input logic [1:0] v, input txn_t t0, input txn_t t1, output int won);
    logic [1:0] exp_rdy;
    won = -1;
    drive(0, t0);
    drive(1, t1);
    req_valid = v;
    for (int k = 0; k < 8; k++) begin
      #1;
      exp_rdy = (cyc >= next_ok) ? (2'b01 << model_winner(v)) : 2'b00;
      check("req_ready", 32'(req_ready), 32'(exp_rdy));
      if ((req_ready & v) != 2'b00) begin
        won = req_ready[1] ? 1 : 0;
        break;
      end
      @(negedge clk);
    end
    if (won < 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL grant_timeout: got no grant want a grant for valid=%b", v);
      req_valid = 2'b00;
      @(negedge clk);
      return;
    end
    model_transfer(won, (won == 1) ? t1 : t0);
    @(posedge clk);
    #1 req_valid = 2'b00;
    @(negedge clk);
  endtask

  // Response monitor: pops the scoreboard whenever the DUT presents a response.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (memWriteEn) wr_seen++;
      if (rsp_valid != 2'b00) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL rsp_unexpected: got rsp_valid=%b want none", rsp_valid);
        end else begin
          e = sb.pop_front();
          check("rsp_port", 32'(rsp_valid), 32'(2'b01 << e.port));
          check("rsp_err", 32'(rsp_err), 32'(e.err));
          check("rsp_rdata", rsp_rdata, e.rdata);
          check("rsp_cycle", cyc, e.cyc);
        end
      end else if (sb.size() > 0 && cyc > sb[0].cyc) begin
        e = sb.pop_front();
        n_cmp++;
        n_fail++;
        $display("FAIL rsp_timeout: got no response want one by cycle %0d", e.cyc);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no end of test want $finish");
    $fatal(1);
  end

  initial begin
    int   won, prev;
    int   fp_next;
    txn_t idle_t, t0, t1;
    DType w;

    idle_t = mk(1'b0, MEM_W, 1'b0, '0, '0);
    for (int i = 0; i < 1024; i++) ref_mem[i] = 8'h00;
    rstn      = 1'b0;
    ram_clr   = 1'b1;
    req_valid = 2'b11;
    fp_valid  = 2'b00;
    drive(0, idle_t);
    drive(1, idle_t);

    // Reset state while requests are held.
    #23;
    check("reset_ready", 32'(req_ready), 32'h0);
    check("reset_rsp_valid", 32'(rsp_valid), 32'h0);
    check("reset_rsp_err", 32'(rsp_err), 32'h0);
    check("reset_rsp_rdata", rsp_rdata, 32'h0);
    check("reset_mwe", 32'(memWriteEn), 32'h0);
    @(negedge clk);
    req_valid = 2'b00;
    ram_clr   = 1'b0;
    rstn      = 1'b1;
    next_ok   = cyc;
    @(negedge clk);

    // Word store then load back.
    offer(2'b01, mk(1'b1, MEM_W, 1'b0, 32'h10, 32'hDEADBEEF), idle_t, won);
    offer(2'b01, mk(1'b0, MEM_W, 1'b0, 32'h10, '0), idle_t, won);

    // Byte store merge into an existing word, then sub-word loads.
    offer(2'b01, mk(1'b1, MEM_W, 1'b0, 32'h20, 32'h11223344), idle_t, won);
    offer(2'b01, mk(1'b1, MEM_B, 1'b0, 32'h21, 32'h000000AA), idle_t, won);
    offer(2'b01, mk(1'b0, MEM_W, 1'b0, 32'h20, '0), idle_t, won);
    offer(2'b01, mk(1'b0, MEM_B, 1'b1, 32'h21, '0), idle_t, won);
    offer(2'b01, mk(1'b0, MEM_B, 1'b0, 32'h21, '0), idle_t, won);
    offer(2'b01, mk(1'b0, MEM_H, 1'b1, 32'h22, '0), idle_t, won);

    // Misaligned word store: error, no write.
    offer(2'b01, mk(1'b1, MEM_W, 1'b0, 32'h13, 32'h55555555), idle_t, won);
    offer(2'b10, mk(1'b0, MEM_H, 1'b0, 32'h21, '0), mk(1'b0, MEM_H, 1'b1, 32'h23, '0), won);

    // Both ports valid at every accepting edge: grants must alternate.
    prev = -1;
    for (int i = 0; i < 4; i++) begin
      offer(2'b11, mk(1'b0, MEM_W, 1'b0, 32'h10, '0), mk(1'b0, MEM_H, 1'b0, 32'h20, '0), won);
      if (prev >= 0) check("rr_alternate", 32'(won), 32'(1 - prev));
      prev = won;
    end

    // Reset asserted during the MERGE cycle of a halfword store.
    drive(0, mk(1'b1, MEM_H, 1'b0, 32'h40, 32'h0000BEEF));
    req_valid = 2'b01;
    won = -1;
    for (int k = 0; k < 8; k++) begin
      #1;
      if (req_ready[0]) begin
        won = 0;
        break;
      end
      @(negedge clk);
    end
    check("abort_granted", 32'(won), 32'h0);
    @(posedge clk);
    #1 req_valid = 2'b00;
    @(posedge clk);
    #1 rstn = 1'b0;
    #1;
    check("abort_mwe", 32'(memWriteEn), 32'h0);
    req_valid = 2'b11;
    #1;
    check("abort_ready", 32'(req_ready), 32'h0);
    @(negedge clk);
    check("abort_rsp_valid", 32'(rsp_valid), 32'h0);
    @(negedge clk);
    check("abort_rsp_valid2", 32'(rsp_valid), 32'h0);
    req_valid = 2'b00;
    rstn      = 1'b1;
    mdl_last  = 1'b1;
    next_ok   = cyc;
    @(negedge clk);
    offer(2'b11, mk(1'b0, MEM_W, 1'b0, 32'h20, '0), mk(1'b0, MEM_W, 1'b0, 32'h10, '0), won);
    check("first_tie_after_reset", 32'(won), 32'h0);

    // Random traffic.
    for (int i = 0; i < 200; i++) begin
      t0 = rand_txn();
      t1 = rand_txn();
      case ($urandom_range(0, 2))
        0:       offer(2'b01, t0, t1, won);
        1:       offer(2'b10, t0, t1, won);
        default: offer(2'b11, t0, t1, won);
      endcase
      if ($urandom_range(0, 4) == 0) @(negedge clk);
    end

    // Fixed-priority instance: port 0 always wins while both are valid.
    drive(0, mk(1'b0, MEM_W, 1'b0, 32'h0, '0));
    drive(1, mk(1'b0, MEM_W, 1'b0, 32'h4, '0));
    fp_next  = cyc;
    fp_valid = 2'b11;
    for (int i = 0; i < 12; i++) begin
      #1;
      check("fp_ready", 32'(fp_ready), (cyc >= fp_next) ? 32'h1 : 32'h0);
      check("fp_no_write", 32'(fp_mwe), 32'h0);
      if (fp_ready != 2'b00) fp_next = cyc + 2;
      @(negedge clk);
    end
    fp_valid = 2'b00;

    // Drain, then compare write count and RAM image against the model.
    repeat (6) @(negedge clk);
    check("sb_empty", sb.size(), 32'h0);
    check("write_count", wr_seen, wr_exp);
    for (int i = 0; i < 256; i++) begin
      w = {ref_mem[4*i+3], ref_mem[4*i+2], ref_mem[4*i+1], ref_mem[4*i]};
      check("ram_word", ram[i], w);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
